// File: rtl/bram_arbiter.sv
// Merges the core's instruction-fetch and data ports onto one single-port BRAM.
// Each port holds one pending request; conflicts resolve round-robin or dmem-first.
module bram_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready,
  output logic        arb_error
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {PORT_IMEM = 1'b0, PORT_DMEM = 1'b1} port_t;

  state_t      state_q, state_d;
  port_t       owner_q, last_grant_q, sel;

  logic        i_pend_q;
  logic [31:0] i_addr_q;
  logic        d_pend_q;
  logic [31:0] d_addr_q;
  logic [31:0] d_wdata_q;
  logic [3:0]  d_wstrb_q;
  logic        arb_error_q;

  logic        rsp;
  logic        grant;
  logic        i_grant, d_grant;
  logic        i_take, d_take;
  logic        i_ovf, d_ovf;

  // Grant decision and next state. A response and a new grant can share a
  // cycle, which is what gives one access per cycle under sustained load.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rsp     = 1'b0;
    grant   = 1'b0;
    sel     = PORT_IMEM;
    state_d = state_q;

    rsp   = (state_q == BUSY) && bram_ready;
    grant = (i_pend_q || d_pend_q) && ((state_q == IDLE) || rsp);

    if (i_pend_q && d_pend_q) begin
      if (ROUND_ROBIN) begin
        sel = (last_grant_q == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
      end else begin
        sel = PORT_DMEM;
      end
    end else if (d_pend_q) begin
      sel = PORT_DMEM;
    end

    if (grant) begin
      state_d = BUSY;
    end else if (rsp) begin
      state_d = IDLE;
    end
  end

  assign i_grant = grant && (sel == PORT_IMEM);
  assign d_grant = grant && (sel == PORT_DMEM);

  // A pulse is accepted into an empty buffer or one being drained this cycle;
  // anything else would overwrite a live request and is flagged instead.
  assign i_take = imem_valid && (!i_pend_q || i_grant);
  assign d_take = dmem_valid && (!d_pend_q || d_grant);
  assign i_ovf  = imem_valid && !i_take;
  assign d_ovf  = dmem_valid && !d_take;

  // BRAM request side: everything but valid is zeroed when idle.
  always_comb begin
    bram_valid = 1'b0;
    bram_instr = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    bram_wstrb = '0;
    if (grant) begin
      bram_valid = 1'b1;
      if (sel == PORT_DMEM) begin
        bram_addr  = d_addr_q;
        bram_wdata = d_wdata_q;
        bram_wstrb = d_wstrb_q;
      end else begin
        bram_instr = 1'b1;
        bram_addr  = i_addr_q;
      end
    end
  end

  // Response routing: only the owner of the in-flight access sees ready/data.
  always_comb begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    if (rsp) begin
      if (owner_q == PORT_DMEM) begin
        dmem_ready = 1'b1;
        dmem_rdata = bram_rdata;
      end else begin
        imem_ready = 1'b1;
        imem_rdata = bram_rdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_IMEM;
      last_grant_q <= PORT_IMEM;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q      <= sel;
        last_grant_q <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_pend_q <= 1'b0;
      i_addr_q <= '0;
    end else if (i_take) begin
      i_pend_q <= 1'b1;
      i_addr_q <= imem_addr;
    end else if (i_grant) begin
      i_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_pend_q  <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wstrb_q <= '0;
    end else if (d_take) begin
      d_pend_q  <= 1'b1;
      d_addr_q  <= dmem_addr;
      d_wdata_q <= dmem_wdata;
      d_wstrb_q <= dmem_wstrb;
    end else if (d_grant) begin
      d_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_error_q <= 1'b0;
    end else if (i_ovf || d_ovf) begin
      arb_error_q <= 1'b1;
    end
  end

  assign arb_error = arb_error_q;

endmodule
